ram_sync_clr: RTL
=================

// Module: ram_sync_clr
// PURPOSE
//  Single-port synchronous RAM for the CPU memory subsystem; next generation of the asynchronous 8x256 RAM.
//  Parametrised width/depth, valid/ready request port, pipelined read response, and a hardware clear sweep after reset.
//  Sits between the bus/memory arbiter and the core; the data bus is split into wdata/rdata (no tri-state).
// PARAMETERS
//  DATA_W    8  data word width, bits
//  ADDR_W    8  address width; depth = 2**ADDR_W words
//  READ_LAT  1  read latency in cycles, request handshake -> rsp_valid; legal 1..4
//  CLEAR_EN  1  1: zero every word after reset before accepting requests; 0: skip sweep, contents undefined
// PORTS
//  clk        in   1         clock; all state changes on rising edge
//  rst_n      in   1         synchronous reset, active low
//  req_valid  in   1         request present
//  req_ready  out  1         block accepts a request this cycle
//  req_write  in   1         1 = write, 0 = read
//  req_addr   in   ADDR_W    word address
//  req_wdata  in   DATA_W    write data
//  rsp_valid  out  1         rsp_rdata valid this cycle (one-cycle pulse per read)
//  rsp_rdata  out  DATA_W    read data
//  clr_busy   out  1         clear sweep in progress
// BEHAVIOUR
//  Reset, rst_n sampled low at an edge:
//   - rsp_valid=0, rsp_rdata=0, read pipeline flushed, clear pointer=0
//   - state=CLEAR if CLEAR_EN, else IDLE
//   - in-flight reads are dropped, never answered; memory array contents are not reset
//  FSM states:
//   - CLEAR: writes 0 to mem[ptr], ptr++ every cycle; req_ready=0, clr_busy=1
//     ptr==2**ADDR_W-1 -> IDLE next cycle; sweep takes exactly 2**ADDR_W cycles after reset release
//   - IDLE: req_ready=1, clr_busy=0; remains until reset
//  Handshake:
//   - transfer when req_valid && req_ready at a rising edge
//   - at most one transfer per cycle; back-to-back accepted
//   - no rsp-side backpressure: the consumer must take rsp_rdata in its valid cycle
//  Write: mem[req_addr] <= req_wdata at the accepting edge; no response.
//  Read:
//   - address captured at the accepting edge
//   - rsp_valid=1 with data exactly READ_LAT cycles later
//   - pipeline of READ_LAT valid/data stages: stage 1 is the array read; later stages are registers
//  Ordering: a read accepted the cycle after a write to the same address returns the new data.
//  rsp_rdata holds its last value while rsp_valid=0; it is not zeroed.
//  Addresses wrap naturally at ADDR_W bits; no out-of-range case exists.
//  Requests while req_ready=0 are ignored; the requester holds them (standard valid/ready).
//  Reset asserted mid-sweep restarts the sweep at address 0.
//  Synthesis: READ_LAT outside 1..4 fails elaboration.
// STRUCTURE
//  Shared package mem_pkg:
//   - FSM state enum {ST_CLEAR, ST_IDLE}
//   - READ_LAT_MAX=4 constant
//  Sub-module ram_sp_core:
//   - bare array plus one registered read port
//   - ports: clk, we, addr, wdata, rdata
//   - the clear sweep drives its write port through a mux
//  The FSM, pipeline and mux live in ram_sync_clr.
// TESTING
//  1. CLEAR_EN=1, ADDR_W=4: release reset -> clr_busy=1, req_ready=0 for 16 cycles, then 1; read 0..15 -> all 0x00
//  2. Write 0xAA@0, write 0xFE@4, read 0, read 4 back-to-back -> rsp_valid pulses READ_LAT cycles after each, data 0xAA then 0xFE
//  3. Write 0x55@7 then read 7 next cycle -> 0x55; repeat with READ_LAT=3 -> same data, 3-cycle latency
//  4. Stream 8 reads, one per cycle, READ_LAT=2 -> 8 consecutive rsp_valid cycles, data in request order
//  5. Assert rst_n=0 with 2 reads in flight -> no rsp_valid afterwards; sweep restarts, clr_busy=1 for 2**ADDR_W cycles
//  6. req_valid held during CLEAR -> no write lands; the request is accepted on the first IDLE cycle

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type and limits for the synchronous RAM family
package mem_pkg;
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
  localparam int READ_LAT_MAX = 4;
endpackage

// File: rtl/ram_sp_core.sv
// ram_sp_core: bare single-port array with one registered read port
module ram_sp_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // write-if-enabled and read-first registered read every cycle
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/ram_sync_clr.sv
// ram_sync_clr: valid/ready single-port RAM with pipelined read and post-reset clear sweep
module ram_sync_clr
  import mem_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1,
  parameter int CLEAR_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              clr_busy
);
  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [READ_LAT-1:0] v;
  logic [DATA_W-1:0] hold, last_d, core_rdata, core_wdata;
  logic [ADDR_W-1:0] core_addr;
  logic              clearing, acc, core_we;

  if (READ_LAT < 1 || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
    $error("READ_LAT must be within 1..%0d", READ_LAT_MAX);
  end

  assign clearing  = state == ST_CLEAR;
  assign req_ready = !clearing;
  assign clr_busy  = clearing;
  assign acc       = req_valid && req_ready;

  // the sweep owns the array port while clearing, otherwise the requester does
  assign core_we    = clearing || (acc && req_write);
  assign core_addr  = clearing ? ptr : req_addr;
  assign core_wdata = clearing ? '0 : req_wdata;

  ram_sp_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
    .clk   (clk),
    .we    (core_we),
    .addr  (core_addr),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  // leave the sweep once the last address has been zeroed
  always_comb state_nx = (clearing && &ptr) ? ST_IDLE : state;

  // state register and sweep pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= (CLEAR_EN != 0) ? ST_CLEAR : ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      if (clearing) ptr <= ptr + 1'b1;
    end
  end

  // read valid pipeline plus the held copy of the last delivered word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v    <= '0;
      hold <= '0;
    end else begin
      v[0] <= acc && !req_write;
      for (int i = 1; i < READ_LAT; i++) v[i] <= v[i-1];
      if (v[READ_LAT-1]) hold <= last_d;
    end
  end

  if (READ_LAT == 1) begin : g_lat1
    assign last_d = core_rdata;
  end else begin : g_latn
    logic [DATA_W-1:0] sd [1:READ_LAT-1];
    // data stages behind the array read register
    always_ff @(posedge clk) begin
      sd[1] <= core_rdata;
      for (int i = 2; i < READ_LAT; i++) sd[i] <= sd[i-1];
    end
    assign last_d = sd[READ_LAT-1];
  end

  assign rsp_valid = v[READ_LAT-1];
  assign rsp_rdata = rsp_valid ? last_d : hold;
endmodule
